// File: rtl/reg_writeback_queue.sv
// Register-file write-back queue: merges ALU and load results into one
// in-order FIFO that drains through a single register-file write port.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_addr,
  input  logic [31:0]              alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [4:0]               mem_addr,
  input  logic [31:0]              mem_data,
  output logic                     mem_ready,
  input  logic                     wr_stall,
  input  logic                     flush,
  output logic                     we,
  output logic [4:0]               addr3,
  output logic [31:0]              WD3,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    addr_mem_q [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          pop_s;
  logic          slot_free_s;
  logic          push_s;
  logic [4:0]    enq_addr_s;
  logic [31:0]   enq_data_s;
  logic [31:0]   pending_s;

  // Handshake, arbitration and write-port drive
  always_comb begin
    empty       = (count_q == {CW{1'b0}});
    full        = (count_q == CW'(DEPTH));
    count       = count_q;
    pop_s       = !empty && !wr_stall && !flush;
    slot_free_s = (count_q < CW'(DEPTH)) || pop_s;
    mem_ready   = !flush && slot_free_s;
    alu_ready   = !flush && !mem_valid && slot_free_s;
    we          = pop_s;
    if (mem_valid) begin
      enq_addr_s = mem_addr;
      enq_data_s = mem_data;
    end else begin
      enq_addr_s = alu_addr;
      enq_data_s = alu_data;
    end
    // Address 0 completes the handshake but is never stored.
    push_s = ((mem_valid && mem_ready) || (alu_valid && alu_ready)) && (enq_addr_s != 5'd0);
    if (empty) begin
      addr3 = 5'd0;
      WD3   = 32'd0;
    end else begin
      addr3 = addr_mem_q[head_q];
      WD3   = data_mem_q[head_q];
    end
  end

  // Pointer and occupancy next-state
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (pop_s) begin
        head_d = head_q + AW'(1);
      end else begin
        head_d = head_q;
      end
      if (push_s) begin
        tail_d = tail_q + AW'(1);
      end else begin
        tail_d = tail_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pending-register scoreboard over the live window head..head+count-1
  always_comb begin
    pending_s = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        pending_s[addr_mem_q[head_q + AW'(k)]] = 1'b1;
      end else begin
        pending_s = pending_s;
      end
    end
    pending = {pending_s[31:1], 1'b0};
  end

  // Queue state and entry storage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {CW{1'b0}};
      for (int k = 0; k < DEPTH; k++) begin
        addr_mem_q[k] <= 5'd0;
        data_mem_q[k] <= 32'd0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push_s) begin
        addr_mem_q[tail_q] <= enq_addr_s;
        data_mem_q[tail_q] <= enq_data_s;
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a queue-based model of the write-back queue.
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0;
  logic [4:0]  alu_addr = 5'd0, mem_addr = 5'd0;
  logic [31:0] alu_data = 32'd0, mem_data = 32'd0;
  logic        wr_stall = 1'b0, flush = 1'b0;
  logic        alu_ready, mem_ready, we, full, empty;
  logic [4:0]  addr3;
  logic [31:0] WD3, pending;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_stall(wr_stall), .flush(flush),
    .we(we), .addr3(addr3), .WD3(WD3), .pending(pending),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Model: expected outputs follow from queue contents and the present inputs.
  task automatic check_all();
    logic        e_pop, e_slot;
    logic [31:0] e_pend;
    e_pop  = (q.size() != 0) && !wr_stall && !flush;
    e_slot = (q.size() < DEPTH) || e_pop;
    e_pend = 32'd0;
    foreach (q[i]) e_pend[q[i].a] = 1'b1;
    cmp("we",        {31'd0, we},        {31'd0, e_pop});
    cmp("mem_ready", {31'd0, mem_ready}, {31'd0, !flush && e_slot});
    cmp("alu_ready", {31'd0, alu_ready}, {31'd0, !flush && !mem_valid && e_slot});
    cmp("addr3",     {27'd0, addr3},     (q.size() != 0) ? {27'd0, q[0].a} : 32'd0);
    cmp("WD3",       WD3,                (q.size() != 0) ? q[0].d : 32'd0);
    cmp("pending",   pending,            e_pend);
    cmp("count",     {29'd0, count},     q.size());
    cmp("full",      {31'd0, full},      {31'd0, q.size() == DEPTH});
    cmp("empty",     {31'd0, empty},     {31'd0, q.size() == 0});
  endtask

  always @(negedge clk) begin
    #2;
    check_all();
  end

  always @(posedge clk) begin
    logic p, s;
    if (reset) begin
      p = (q.size() != 0) && !wr_stall && !flush;
      s = (q.size() < DEPTH) || p;
      if (flush) begin
        q.delete();
      end else begin
        if (p) void'(q.pop_front());
        if (mem_valid && s) begin
          if (mem_addr != 5'd0) q.push_back('{a: mem_addr, d: mem_data});
        end else if (alu_valid && s && alu_addr != 5'd0) begin
          q.push_back('{a: alu_addr, d: alu_data});
        end
      end
    end
  end

  always @(negedge reset) q.delete();

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic st, input logic fl);
    @(negedge clk);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    wr_stall = st; flush = fl;
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, st, 1'b0);
  endtask

  task automatic async_reset_pulse();
    #3 reset = 1'b0;
    #1;
    cmp("rst_count", {29'd0, count}, 32'd0);
    cmp("rst_we",    {31'd0, we},    32'd0);
    cmp("rst_empty", {31'd0, empty}, 32'd1);
    cmp("rst_pend",  pending,        32'd0);
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    cmp("reset_count", {29'd0, count}, 32'd0);
    cmp("reset_empty", {31'd0, empty}, 32'd1);
    cmp("reset_full",  {31'd0, full},  32'd0);
    cmp("reset_WD3",   WD3,            32'd0);

    // Single write
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #4 cmp("single_ready", {31'd0, alu_ready}, 32'd1);
    idle(1'b0);
    #4;
    cmp("single_we",   {31'd0, we},    32'd1);
    cmp("single_addr", {27'd0, addr3}, 32'd5);
    cmp("single_data", WD3,            32'hDEADBEEF);
    cmp("single_pend", pending,        32'h0000_0020);
    idle(1'b0);
    #4;
    cmp("single_empty", {31'd0, empty}, 32'd1);
    cmp("single_pend0", pending,        32'd0);

    // Priority
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0);
    #4;
    cmp("prio_mem_ready", {31'd0, mem_ready}, 32'd1);
    cmp("prio_alu_ready", {31'd0, alu_ready}, 32'd0);
    drive(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    #4 cmp("prio_first", {27'd0, addr3}, 32'd4);
    idle(1'b0);
    #4 cmp("prio_second", {27'd0, addr3}, 32'd3);
    idle(1'b0);

    // Full and wrap
    for (int i = 1; i <= 4; i++) drive(1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(100 + i), 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd105, 1'b1, 1'b0);
    #4;
    cmp("wrap_full",      {31'd0, full},      32'd1);
    cmp("wrap_count",     {29'd0, count},     32'd4);
    cmp("wrap_mem_ready", {31'd0, mem_ready}, 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd105, 1'b0, 1'b0);
    #4;
    cmp("wrap_ready_pop", {31'd0, mem_ready}, 32'd1);
    cmp("wrap_head1",     {27'd0, addr3},     32'd1);
    for (int i = 2; i <= 5; i++) begin
      idle(1'b0);
      #4 cmp("wrap_order", {27'd0, addr3}, 32'(i));
    end
    idle(1'b0);
    #4 cmp("wrap_drained", {31'd0, empty}, 32'd1);

    // Address 0 discarded
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF, 1'b0, 1'b0);
    #4 cmp("a0_ready", {31'd0, mem_ready}, 32'd1);
    idle(1'b0);
    #4;
    cmp("a0_count", {29'd0, count}, 32'd0);
    cmp("a0_we",    {31'd0, we},    32'd0);
    cmp("a0_pend",  pending,        32'd0);

    // Flush
    for (int i = 7; i <= 9; i++) drive(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    drive(1'b1, 5'd10, 32'd10, 1'b1, 5'd11, 32'd11, 1'b0, 1'b1);
    #4;
    cmp("flush_alu_ready", {31'd0, alu_ready}, 32'd0);
    cmp("flush_mem_ready", {31'd0, mem_ready}, 32'd0);
    cmp("flush_we",        {31'd0, we},        32'd0);
    idle(1'b0);
    #4;
    cmp("flush_count", {29'd0, count}, 32'd0);
    cmp("flush_we2",   {31'd0, we},    32'd0);

    // Asynchronous reset with two entries queued
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'd12, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'd13, 1'b1, 1'b0);
    idle(1'b0);
    async_reset_pulse();
    idle(1'b0);
    #4 cmp("rst_no_stale", {31'd0, we}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 99) < 50,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
            $urandom_range(0, 99) < 40,
            ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
            $urandom_range(0, 99) < 35,
            $urandom_range(0, 99) < 4);
      if (i % 700 == 350) async_reset_pulse();
    end
    idle(1'b0);
    repeat (6) idle(1'b0);
    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
